// File: rtl/mem_bus_pkg.sv
// Shared bus-memory definitions: transfer FSM states, lane count and MIPS constants
// used by both the wait-state RAM and the CPU bench.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } bus_state_e;

    localparam int          BYTE_LANES        = 4;
    localparam int          WORD_BYTES        = 4;
    localparam logic [31:0] MIPS_RESET_VECTOR = 32'hBFC0_0000;

    // Byte address -> word index relative to a base, before truncation to the RAM depth.
    function automatic logic [31:0] word_offset(input logic [31:0] addr, input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Word-wide RAM with per-byte write enables and an asynchronous read port.
module byte_lane_ram
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                  clk_i,
    input  logic [BYTE_LANES-1:0] we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (we_i[i]) begin
                mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/avalon_wait_ram.sv
// Avalon-MM slave memory that stalls every transfer for WAIT_CYCLES cycles,
// supports a priority preload port and flags master protocol violations.
module avalon_wait_ram
    import mem_bus_pkg::*;
#(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    input  logic        inst_input,
    input  logic [7:0]  inst_addr,
    input  logic [31:0] instruction,
    output logic        err_protocol
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    bus_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q;
    logic [31:0] addr_q;
    logic        is_write_q;
    logic        capture;
    logic        load_rdata;
    logic        one_req;

    logic [ADDR_W-1:0]     bus_idx;
    logic [ADDR_W-1:0]     held_idx;
    logic [ADDR_W-1:0]     pl_idx;
    logic [BYTE_LANES-1:0] ram_we;
    logic [ADDR_W-1:0]     ram_waddr;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;

    assign one_req  = read ^ write;
    assign bus_idx  = ADDR_W'(word_offset(address, BASE_ADDR));
    assign held_idx = ADDR_W'(word_offset(addr_q, BASE_ADDR));
    assign pl_idx   = ADDR_W'({24'd0, inst_addr} >> 2);

    // The bus only gets its ack while the preload port is quiet.
    assign waitrequest  = (read | write) && ((state_q != ACK) || inst_input);
    assign readdata     = rdata_q;
    assign err_protocol = err_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        capture    = 1'b0;
        load_rdata = 1'b0;
        if (!inst_input) begin
            case (state_q)
                IDLE: begin
                    if (read && write) begin
                        err_d = 1'b1;
                    end else if (one_req) begin
                        capture = 1'b1;
                        if (WAIT_LOAD == 4'd0) begin
                            state_d    = ACK;
                            cnt_d      = 4'd0;
                            load_rdata = read;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    // The request must stay identical for the whole stall.
                    if (!one_req || (write != is_write_q) || (address != addr_q)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else if (cnt_q == 4'd1) begin
                        state_d    = ACK;
                        cnt_d      = 4'd0;
                        load_rdata = !is_write_q;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ACK: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ram_we    = '0;
        ram_waddr = held_idx;
        ram_wdata = writedata;
        if (inst_input) begin
            ram_we    = '1;
            ram_waddr = pl_idx;
            ram_wdata = instruction;
        end else if ((state_q == ACK) && is_write_q) begin
            ram_we = byteenable;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
            is_write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (load_rdata) begin
                rdata_q <= ram_rdata;
            end
            if (capture) begin
                is_write_q <= write;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            addr_q <= address;
        end
    end

    byte_lane_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (bus_idx),
        .rdata_o (ram_rdata)
    );

endmodule
